// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter: FSM states, BCD digit
// and MM:SS word types, and per-digit modulus limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [15:0] mmss_t;

    localparam bcd_digit_t DIGIT_MAX_UNITS = 4'd9;
    localparam bcd_digit_t DIGIT_MAX_TENS  = 4'd5;

    function automatic logic mmss_is_zero(input mmss_t value);
        return (value == 16'h0000);
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One modulo-(MAX+1) BCD digit: advances on i_en, wraps to zero after MAX and
// raises o_carry in the same cycle so the next digit can advance.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_digit_t MAX = DIGIT_MAX_UNITS
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    output bcd_digit_t o_q,
    output logic       o_carry
);

    bcd_digit_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= (r_q == MAX) ? bcd_digit_t'(0) : r_q + 4'd1;
        end
    end

    assign o_q     = r_q;
    assign o_carry = i_en && (r_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch with run/pause, limit compare via external comparator.
// Optional lap capture compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        limit_load,
    input  logic [15:0] limit_in,
    input  logic        cmp_ge,
    output logic [15:0] count,
    output logic [15:0] limit,
    output logic        running,
    output logic        done,
    output logic        alarm
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic        lap,
    output logic [15:0] lap_time
`endif
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    sw_state_t           r_state;
    sw_state_t           w_state_nxt;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  w_presc_nxt;
    mmss_t               r_limit;
    logic                r_done;
    logic                w_cmp_hit;
    logic                w_tick;
    logic [4:0]          w_carry;
    mmss_t               w_count;
    logic                w_unused_wrap;

    // Compare only counts while running; a zero limit means free-running.
    assign w_cmp_hit = (r_state == ST_RUN) && cmp_ge && !mmss_is_zero(r_limit);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_tick      = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_stop) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_cmp_hit) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        if (start_stop) w_state_nxt = ST_PAUSE;
                        if (r_presc == PRESC_MAX) begin
                            w_tick = 1'b1;
                        end else begin
                            w_presc_nxt = r_presc + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    w_presc_nxt = r_presc;
                    if (start_stop) w_state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= (r_state != ST_DONE) && (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_limit <= '0;
        end else if (limit_load && !clear &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
            r_limit <= limit_in;
        end
    end

    // Digit chain, least significant first: ss units, ss tens, mm units, mm tens.
    assign w_carry[0] = w_tick;

    bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_sec_units (
        .i_clk(clk), .i_rst(rst), .i_clr(clear), .i_en(w_carry[0]),
        .o_q(w_count[3:0]), .o_carry(w_carry[1])
    );

    bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
        .i_clk(clk), .i_rst(rst), .i_clr(clear), .i_en(w_carry[1]),
        .o_q(w_count[7:4]), .o_carry(w_carry[2])
    );

    bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_min_units (
        .i_clk(clk), .i_rst(rst), .i_clr(clear), .i_en(w_carry[2]),
        .o_q(w_count[11:8]), .o_carry(w_carry[3])
    );

    bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_min_tens (
        .i_clk(clk), .i_rst(rst), .i_clr(clear), .i_en(w_carry[3]),
        .o_q(w_count[15:12]), .o_carry(w_carry[4])
    );

    // Rollover past 59:59 needs no extra action: every digit wraps on its own.
    assign w_unused_wrap = w_carry[4];

`ifdef STOPWATCH_LAP_EN
    mmss_t r_lap_time;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_lap_time <= '0;
        end else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
            r_lap_time <= w_count;
        end
    end

    assign lap_time = r_lap_time;
`endif

    assign count   = w_count;
    assign limit   = r_limit;
    assign running = (r_state == ST_RUN);
    assign alarm   = (r_state == ST_DONE);
    assign done    = r_done;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: seconds-level reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_stopwatch_counter;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        limit_load = 1'b0;
    logic [15:0] limit_in = 16'h0000;
    logic        cmp_ge;
    logic [15:0] count;
    logic [15:0] limit;
    logic        running;
    logic        done;
    logic        alarm;
`ifdef STOPWATCH_LAP_EN
    logic        lap = 1'b0;
    logic [15:0] lap_time;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External comparator: BCD words order the same way as their values.
    assign cmp_ge = (count >= limit);

    stopwatch_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
        .limit_load(limit_load), .limit_in(limit_in), .cmp_ge(cmp_ge),
        .count(count), .limit(limit), .running(running), .done(done),
        .alarm(alarm)
`ifdef STOPWATCH_LAP_EN
        , .lap(lap), .lap_time(lap_time)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed time kept as plain seconds.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} m_state_t;
    m_state_t    m_state = M_IDLE;
    int          m_secs = 0;
    int          m_phase = 0;
    logic [15:0] m_limit = 16'h0;
    logic [15:0] m_lap = 16'h0;
    logic        m_done = 1'b0;
    logic        m_valid = 1'b0;

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    always @(posedge clk) begin
        logic hit;
        logic lap_in;
`ifdef STOPWATCH_LAP_EN
        lap_in = lap;
`else
        lap_in = 1'b0;
`endif
        if (rst) begin
            m_state = M_IDLE; m_secs = 0; m_phase = 0;
            m_limit = 16'h0; m_lap = 16'h0; m_done = 1'b0; m_valid = 1'b1;
        end else begin
            hit = (m_state == M_RUN) && (m_limit != 16'h0) && (to_bcd(m_secs) >= m_limit);
            m_done = 1'b0;
            if (clear) begin
                m_state = M_IDLE; m_secs = 0; m_phase = 0; m_lap = 16'h0;
            end else begin
                if (limit_load && (m_state == M_IDLE || m_state == M_DONE))
                    m_limit = limit_in;
                if (lap_in && (m_state == M_RUN || m_state == M_PAUSE))
                    m_lap = to_bcd(m_secs);
                case (m_state)
                    M_IDLE: begin
                        m_phase = 0;
                        if (start_stop) m_state = M_RUN;
                    end
                    M_RUN: begin
                        if (hit) begin
                            m_state = M_DONE; m_done = 1'b1; m_phase = 0;
                        end else begin
                            m_phase = m_phase + 1;
                            if (m_phase == CLK_DIV) begin
                                m_phase = 0;
                                m_secs = (m_secs + 1) % 3600;
                            end
                            if (start_stop) m_state = M_PAUSE;
                        end
                    end
                    M_PAUSE: if (start_stop) m_state = M_RUN;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("model_count", count, to_bcd(m_secs));
            check("model_limit", limit, m_limit);
            check("model_running", 16'(running), 16'(m_state == M_RUN));
            check("model_alarm", 16'(alarm), 16'(m_state == M_DONE));
            check("model_done", 16'(done), 16'(m_done));
`ifdef STOPWATCH_LAP_EN
            check("model_lap_time", lap_time, m_lap);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    task automatic load_limit(input logic [15:0] v);
        limit_in = v; limit_load = 1'b1; cyc(1); limit_load = 1'b0;
    endtask

    initial begin
        int n;
        int dn;
        cyc(2);
        rst = 1'b0;
        check("rst_count", count, 16'h0000);
        check("rst_limit", limit, 16'h0000);
        check("rst_running", 16'(running), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_alarm", 16'(alarm), 16'h0);

        // First second after CLK_DIV cycles, ten seconds after 40.
        pulse_ss();
        cyc(3);
        check("tick_not_yet", count, 16'h0000);
        cyc(1);
        check("tick_1s", count, 16'h0001);
        cyc(36);
        check("tick_10s", count, 16'h0010);

        // Pause holds count and prescaler phase.
        pulse_clear();
        pulse_ss();
        cyc(12);
        check("pause_pre", count, 16'h0003);
        pulse_ss();
        cyc(20);
        check("pause_hold", count, 16'h0003);
        check("pause_running", 16'(running), 16'h0);
        pulse_ss();
        cyc(2);
        check("resume_partial", count, 16'h0003);
        cyc(1);
        check("resume_tick", count, 16'h0004);

        // limit_load ignored in RUN; clear beats start_stop.
        pulse_clear();
        pulse_ss();
        cyc(28);
        check("run_7s", count, 16'h0007);
        load_limit(16'h0100);
        check("limit_ignored_run", limit, 16'h0000);
        clear = 1'b1; start_stop = 1'b1; cyc(1); clear = 1'b0; start_stop = 1'b0;
        check("clr_ss_count", count, 16'h0000);
        check("clr_ss_running", 16'(running), 16'h0);
        cyc(8);
        check("clr_ss_stays_idle", count, 16'h0000);

        // Limit reached: stop at 00:05, single done pulse, start_stop ignored.
        load_limit(16'h0005);
        check("limit_loaded", limit, 16'h0005);
        pulse_ss();
        n = 0; dn = 0;
        while (!alarm && n < 100) begin
            cyc(1); n++; dn += int'(done);
        end
        check("done_within_bound", 16'(n < 100), 16'h1);
        repeat (5) begin cyc(1); dn += int'(done); end
        check("done_pulses", 16'(dn), 16'h0001);
        check("done_count", count, 16'h0005);
        check("done_alarm", 16'(alarm), 16'h1);
        pulse_ss();
        cyc(3);
        check("done_ss_alarm", 16'(alarm), 16'h1);
        check("done_ss_running", 16'(running), 16'h0);
        check("done_ss_count", count, 16'h0005);
        pulse_clear();
        check("done_clr_alarm", 16'(alarm), 16'h0);
        check("done_clr_count", count, 16'h0000);
        check("done_clr_limit", limit, 16'h0005);

        // Free-running wrap from 59:59.
        load_limit(16'h0000);
        pulse_ss();
        cyc(3599 * CLK_DIV);
        check("wrap_pre", count, 16'h5959);
        cyc(CLK_DIV);
        check("wrap_count", count, 16'h0000);
        check("wrap_alarm", 16'(alarm), 16'h0);
        check("wrap_running", 16'(running), 16'h1);

`ifdef STOPWATCH_LAP_EN
        cyc(2 * CLK_DIV);
        check("lap_pre", count, 16'h0002);
        lap = 1'b1; cyc(1); lap = 1'b0;
        check("lap_time", lap_time, 16'h0002);
        cyc(CLK_DIV - 1);
        check("lap_count_continues", count, 16'h0003);
`endif

        // Reset mid-run overrides everything.
        pulse_clear();
        load_limit(16'h0030);
        pulse_ss();
        cyc(10);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("midrst_count", count, 16'h0000);
        check("midrst_limit", limit, 16'h0000);
        check("midrst_running", 16'(running), 16'h0);
        check("midrst_alarm", 16'(alarm), 16'h0);
        check("midrst_done", 16'(done), 16'h0);
`ifdef STOPWATCH_LAP_EN
        check("midrst_lap", lap_time, 16'h0000);
`endif
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, clk cycles per one-second tick (min 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_stop  input  1  one-cycle pulse: run/pause toggle.
REQ-005 SHALL have port clear  input  1  one-cycle pulse: return to IDLE, count zeroed.
REQ-006 SHALL have port limit_load  input  1  one-cycle pulse: capture limit_in.
REQ-007 SHALL have port limit_in  input  16  BCD MM:SS target, [15:12] tens-min to [3:0] units-sec.
REQ-008 SHALL have port cmp_ge  input  1  external 16-bit comparator result, 1 when count >= limit.
REQ-009 SHALL have port count  output  16  registered BCD MM:SS elapsed time, comparator A operand.
REQ-010 SHALL have port limit  output  16  registered BCD target, comparator B operand.
REQ-011 SHALL have port running  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-013 SHALL have port alarm  output  1  high in DONE.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 in RUN only, producing an internal tick on terminal count; it holds in PAUSE and is zeroed in IDLE/DONE.
REQ-016 On tick, count SHALL increment in BCD: units-sec 0-9, tens-sec 0-5, units-min 0-9, tens-min 0-5; 59:59 + tick wraps to 00:00.
REQ-017 Transitions: IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN; RUN --(cmp_ge & limit!=0)--> DONE; any --clear--> IDLE.
REQ-018 In RUN, a cycle with cmp_ge=1 and limit!=0 SHALL enter DONE and suppress any tick that cycle; count holds at its compared value.
REQ-019 limit==16'h0000 SHALL disable the compare (free-running, wraps per REQ-016).
REQ-020 start_stop in DONE SHALL be ignored; only clear or rst leaves DONE.
REQ-021 limit_load SHALL take effect only in IDLE or DONE; ignored in RUN/PAUSE.
REQ-022 Simultaneous events: clear beats start_stop and limit_load; the compare-exit (REQ-018) beats start_stop.
REQ-023 clear SHALL zero count and prescaler, keep limit, set IDLE next cycle.
REQ-024 Outputs running, alarm SHALL be decoded from registered state; done SHALL be registered.

Reset
REQ-025 On rst: state IDLE, count 16'h0000, limit 16'h0000, prescaler 0, running 0, done 0, alarm 0 (plus REQ-028 lap state).
REQ-026 rst SHALL override all other inputs, including mid-count and in DONE.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN SHALL compile in lap capture: input lap (1-bit pulse), output lap_time (16).
REQ-028 With STOPWATCH_LAP_EN: lap in RUN or PAUSE copies count to lap_time next cycle; lap_time cleared by rst and clear; lap ignored in IDLE/DONE.
REQ-029 Without STOPWATCH_LAP_EN: ports lap and lap_time SHALL not exist; no lap register.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum, BCD digit typedef (4-bit), MM:SS word typedef (16-bit), and digit max constants (9, 5).
REQ-031 Sub-module bcd_digit SHALL implement one modulo-N BCD digit with enable in, carry out, sync clear; instantiated four times.

Verification
REQ-032 CLK_DIV=4, rst, start_stop -> count 00:01 after 4 clk, 00:10 after 40 clk.
REQ-033 Preload count 59:59 (run 3599 ticks), limit 0 -> next tick count 00:00, alarm 0.
REQ-034 limit 00:05 loaded in IDLE, run, cmp_ge modelled as count>=limit -> count stops at 00:05, done one pulse, alarm 1, start_stop ignored.
REQ-035 Run to 00:03, start_stop -> PAUSE, hold 20 clk count stays 00:03, start_stop resumes, 00:04 after remaining prescaler cycles.
REQ-036 clear and start_stop same cycle in RUN at 00:07 -> IDLE, count 00:00, running 0; limit_load in RUN -> limit unchanged.
REQ-037 STOPWATCH_LAP_EN: lap at 00:02 in RUN -> lap_time 00:02, count continues; rst mid-run -> all outputs 0.
